// File: rtl/piso_serializer_if.sv
// Handshake/bus bundle for piso_serializer.
// Valid/ready semantics: a word transfers on the rising clk edge where
// load (valid) and ready are both high. data_in need only be stable at that
// edge. shift is an unconditional bit tick and has no ready qualifier.
// The master drives data_in/load/shift. The slave (the serializer) drives
// ready/busy/piso_out/done.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             shift;
  logic             ready;
  logic             busy;
  logic             piso_out;
  logic             done;

  modport master (
    output data_in, load, shift,
    input  ready, busy, piso_out, done
  );

  modport slave (
    input  data_in, load, shift,
    output ready, busy, piso_out, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter for the UART TX path.
// A word is accepted on load && ready. Its first bit appears on piso_out at
// the accepting edge. Each shift tick then advances one bit. done pulses for
// one clk at the edge that retires the word.
// Optional feature macro: PISO_PARITY_EN appends a parity bit after the data
// bits. PARITY_ODD selects the parity sense.
module piso_serializer #(
  parameter int WIDTH      = 8,
  parameter bit LSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   bus,
  output logic [1:0]         dbg_state_o
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`else
  // PARITY_ODD has no role when the parity bit is compiled out.
  wire              parity_odd_unused = PARITY_ODD;
`endif

  // State register and datapath registers. Reset drops any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic. The shift register holds only the bits not yet shown,
  // so the next bit is always at the same end of sreg_q.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A tick arriving with load is ignored, so bit 0 gets a full tick period.
        out_d = IDLE_LEVEL;
        if (bus.load) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          if (LSB_FIRST) begin
            out_d  = bus.data_in[0];
            sreg_d = bus.data_in >> 1;
          end else begin
            out_d  = bus.data_in[WIDTH-1];
            sreg_d = bus.data_in << 1;
          end
`ifdef PISO_PARITY_EN
          par_d = (^bus.data_in) ^ PARITY_ODD;
`endif
        end
      end
      S_SHIFT: begin
        if (bus.shift) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
`ifdef PISO_PARITY_EN
            state_d = S_PARITY;
            out_d   = par_q;
`else
            state_d = S_IDLE;
            out_d   = IDLE_LEVEL;
            done_d  = 1'b1;
`endif
          end else if (LSB_FIRST) begin
            out_d  = sreg_q[0];
            sreg_d = sreg_q >> 1;
          end else begin
            out_d  = sreg_q[WIDTH-1];
            sreg_d = sreg_q << 1;
          end
        end
      end
`ifdef PISO_PARITY_EN
      S_PARITY: begin
        if (bus.shift) begin
          state_d = S_IDLE;
          out_d   = IDLE_LEVEL;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        out_d   = IDLE_LEVEL;
      end
    endcase
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.piso_out = out_q;
  assign bus.done     = done_q;
  assign dbg_state_o  = state_q;

endmodule
